// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF, LS and memory-side signals of the memory port arbiter.
// Modport master: arbiter view (takes requests, drives grants/responses and the memory request).
// Modport slave:  environment view (requesters plus memory drive requests, ready and responses).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  // instruction fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // load/store side
  logic              ls_req;
  logic              ls_wen;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [MASK_W-1:0] ls_wmask;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  // memory side
  logic              mem_req;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and load/store, one transaction in flight.
// Latency: grant is combinational in IDLE, mem_req one cycle after grant, response two or more cycles after grant.
// Backpressure: request fields are held stable while mem_ready is low; no new grant until the response returns.
// Ports: clk, rst (synchronous, active-high), bus (mem_port_arbiter_if.master: IF/LS request,
//   grant and response signals, memory request/response signals, busy).
module mem_port_arbiter #(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.master    bus
);
  localparam int MASK_W   = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_ls_q, owner_ls_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;

  logic if_gnt, ls_gnt, if_rvalid, ls_rvalid;
  logic ls_wins;

  // LS has priority unless it has already beaten a waiting IF MAX_LS_STREAK times in a row.
  assign ls_wins = bus.ls_req && !(bus.if_req && (streak_q == STREAK_MAX));

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    ls_rvalid  = 1'b0;

    case (state_q)
      IDLE: begin
        // Grants are suppressed during reset so nothing is captured that reset then discards.
        if (!rst && (bus.if_req || bus.ls_req)) begin
          state_d = ISSUE;
          if (ls_wins) begin
            ls_gnt     = 1'b1;
            owner_ls_d = 1'b1;
            addr_d     = bus.ls_addr;
            wen_d      = bus.ls_wen;
            wdata_d    = bus.ls_wdata;
            wmask_d    = bus.ls_wmask;
            // A waiting IF lengthens the streak; it never passes the max because IF wins there.
            if (bus.if_req) streak_d = streak_q + STREAK_W'(1);
            else            streak_d = '0;
          end else begin
            if_gnt     = 1'b1;
            owner_ls_d = 1'b0;
            addr_d     = bus.if_addr;
            wen_d      = 1'b0;
            wdata_d    = '0;
            wmask_d    = '0;
            streak_d   = '0;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_ready) state_d = WAIT;
      end
      WAIT: begin
        // Response goes only to the recorded owner; a response arriving during reset is dropped.
        if (bus.mem_rvalid && !rst) begin
          state_d = IDLE;
          if (owner_ls_q) ls_rvalid = 1'b1;
          else            if_rvalid = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_ls_q <= 1'b0;
      streak_q   <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.if_rvalid = if_rvalid;
  assign bus.ls_rvalid = ls_rvalid;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;

  assign bus.mem_req   = (state_q == ISSUE);
  assign bus.mem_wen   = wen_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
